risc_multicycle_ctrl: RTL and testbench
=======================================

# risc_multicycle_ctrl

Multi-cycle control FSM for the RiSC-16 core. It sequences fetch, decode, execute, memory and writeback for the eight RiSC-16 opcodes. It drives the one-hot ALU function selects (add, nand, pass1, eq) and the datapath muxes, register-file write, PC load and a req/ack memory handshake. It sits between the instruction register/memory port and the datapath that contains the ALU, and also keeps a retired-instruction counter.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  single clock; everything on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  3  IR[15:13]; valid from DECODE onward, stable until next ir_load
- eq_out  in  1  ALU equality flag
- mem_ack  in  1  memory handshake acknowledge
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write (SW data phase)
- addr_sel  out  1  0 = PC, 1 = alu_out
- ir_load  out  1  one-cycle pulse: capture fetched word into IR
- pc_load  out  1  one-cycle pulse: update PC
- pc_sel  out  2  0 = PC+1, 1 = PC+1+sext(imm7), 2 = alu_out
- alu_add, alu_nand, alu_pass1, alu_eq  out  1 each  ALU selects; at most one high
- src1_zero  out  1  force ALU src1 to 0
- src2_sel  out  2  0 = regC/regB operand, 1 = sext(imm7), 2 = imm10<<6
- rf_we  out  1  register-file write enable (r0 write suppression is the register file's job)
- wb_sel  out  2  0 = alu_out, 1 = memory data, 2 = PC+1
- state  out  3  current state code (debug)
- retired  out  CNT_W  count of completed instructions

## Operation
- Opcodes: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- States and codes: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5. Codes 6 and 7 go to IDLE.
- IDLE: all outputs 0 except state and retired. Go to FETCH when run=1.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ack, pulse ir_load in the same cycle and go to DECODE. Otherwise stay.
- DECODE: one cycle, no outputs asserted. Go to EXEC.
- EXEC selects:
  - ADD: add, src2 0.
  - ADDI: add, src2 1.
  - NAND: nand, src2 0.
  - LUI: add, src1_zero, src2 2.
  - SW/LW: add, src2 1.
  - BEQ: eq, src2 0.
  - JALR: pass1.
- EXEC next state:
  - ADD, ADDI, NAND, LUI, JALR go to WB.
  - SW and LW go to MEM.
  - BEQ pulses pc_load with pc_sel = eq_out ? 1 : 0, then goes to the boundary.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(opcode==SW). ALU add/src2=1 held.
  - On mem_ack: SW pulses pc_load with pc_sel 0 and goes to the boundary; LW goes to WB. Otherwise stay.
- WB:
  - rf_we=1 for one cycle, and pc_load is pulsed in the same cycle.
  - wb_sel: 1 for LW, 2 for JALR, 0 otherwise.
  - pc_sel: 2 for JALR, 0 otherwise.
  - For JALR, alu_pass1 stays high in WB so alu_out is the target.
  - Then go to the boundary.
- Boundary: next state is FETCH if run=1, IDLE if run=0.
- retired increments by 1 on every pc_load pulse and wraps modulo 2^CNT_W.
- mem_ack outside FETCH/MEM is ignored. mem_req never drops before mem_ack.

## Timing
- Reset: state=IDLE, retired=0, all control outputs 0 on the cycle after rst is sampled high. rst overrides every transition, including mid-FETCH/MEM with mem_req pending; the request is abandoned.
- State outputs are Moore. The exceptions are ir_load, the BEQ/SW pc_load, and its pc_sel, which are Mealy on the current-cycle mem_ack/eq_out.
- Zero-wait memory (mem_ack high in the first request cycle) gives these cycles per instruction:
  - ADD/ADDI/NAND/LUI/JALR: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
- Each wait cycle adds 1.
- run dropping mid-instruction does not abort; the instruction completes. run=1 in IDLE reaches FETCH on the next edge.

## Test plan
- Reset mid-MEM of LW with mem_ack=0 → next cycle state=0, mem_req=0, retired=0; no rf_we ever pulsed.
- run=1, ack tied high, ADD then NAND → states 1,2,3,5 per instruction; alu_add high only in EXEC of the first, alu_nand only in the second; rf_we one cycle each; retired=2 after 8 cycles.
- LW with mem_ack delayed 3 cycles in MEM → mem_req/addr_sel=1 held 4 cycles; WB has wb_sel=1; total 8 cycles.
- BEQ with eq_out=1 and eq_out=0 → 3-cycle instruction; pc_load pulse in EXEC with pc_sel=1 and 0 respectively; rf_we never high.
- JALR → WB has alu_pass1=1, wb_sel=2, pc_sel=2, rf_we=1 in the same cycle.
- CNT_W=2, five back-to-back SW instructions → mem_we=1 only in MEM; retired sequence 1,2,3,0,1; run=0 during the fifth → IDLE after its pc_load.

Source files
------------

// File: rtl/risc_multicycle_ctrl.sv
// risc_multicycle_ctrl
// --------------------
// Multi-cycle control sequencer for the RiSC-16 core. It walks every
// instruction through FETCH, DECODE, EXEC and, where the opcode needs them,
// MEM and WB. It drives the one-hot ALU function selects, the datapath mux
// selects, the register-file write enable, the PC load strobe and a req/ack
// memory handshake. It also counts retired instructions.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   run        level; 1 = keep executing, 0 = stop at next instruction boundary
//   opcode     IR[15:13], valid from DECODE until the next ir_load
//   eq_out     ALU equality flag (BEQ outcome)
//   mem_ack    memory acknowledge
//   mem_req    memory request, held until mem_ack
//   mem_we     memory write (SW data phase)
//   addr_sel   memory address source: 0 = PC, 1 = alu_out
//   ir_load    capture fetched word into IR (one-cycle pulse)
//   pc_load    update PC (one-cycle pulse, one per retired instruction)
//   pc_sel     next-PC source: 0 = PC+1, 1 = PC+1+sext(imm7), 2 = alu_out
//   alu_add / alu_nand / alu_pass1 / alu_eq   one-hot ALU function selects
//   src1_zero  force ALU operand 1 to zero (LUI)
//   src2_sel   ALU operand 2: 0 = register, 1 = sext(imm7), 2 = imm10<<6
//   rf_we      register-file write enable
//   wb_sel     write-back source: 0 = alu_out, 1 = memory data, 2 = PC+1
//   state      current state code (debug)
//   retired    completed-instruction count, wraps modulo 2^CNT_W

module risc_multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [2:0]       opcode,
   input  logic             eq_out,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_load,
   output logic             pc_load,
   output logic [1:0]       pc_sel,
   output logic             alu_add,
   output logic             alu_nand,
   output logic             alu_pass1,
   output logic             alu_eq,
   output logic             src1_zero,
   output logic [1:0]       src2_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_ALU    = 2'd2;

   localparam logic [1:0] SRC2_REG  = 2'd0;
   localparam logic [1:0] SRC2_IMM7 = 2'd1;
   localparam logic [1:0] SRC2_UPR  = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC1 = 2'd2;

   state_t state_q;
   state_t state_d;

   // State register. Reset wins over every transition, so a pending memory
   // request in FETCH or MEM is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Retired-instruction counter. Every instruction ends with exactly one
   // pc_load pulse, so that strobe doubles as the retire event.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired <= '0;
      end else if (pc_load) begin
         retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign state = state_q;

   // Next-state and output decode. Outputs are Moore on the state except
   // ir_load (FETCH ack), the SW pc_load (MEM ack) and the BEQ pc_sel, which
   // follow the same-cycle mem_ack / eq_out. Every instruction that finishes
   // returns to FETCH or IDLE depending on run at that moment, so run only
   // takes effect at an instruction boundary.
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_sel    = PC_INC;
      alu_add   = 1'b0;
      alu_nand  = 1'b0;
      alu_pass1 = 1'b0;
      alu_eq    = 1'b0;
      src1_zero = 1'b0;
      src2_sel  = SRC2_REG;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_load = 1'b1;
               state_d = DECODE;
            end
         end

         DECODE: begin
            state_d = EXEC;
         end

         EXEC: begin
            case (opcode)
               OP_ADD: begin
                  alu_add = 1'b1;
                  state_d = WB;
               end
               OP_ADDI: begin
                  alu_add  = 1'b1;
                  src2_sel = SRC2_IMM7;
                  state_d  = WB;
               end
               OP_NAND: begin
                  alu_nand = 1'b1;
                  state_d  = WB;
               end
               OP_LUI: begin
                  alu_add   = 1'b1;
                  src1_zero = 1'b1;
                  src2_sel  = SRC2_UPR;
                  state_d   = WB;
               end
               OP_SW, OP_LW: begin
                  alu_add  = 1'b1;
                  src2_sel = SRC2_IMM7;
                  state_d  = MEM;
               end
               OP_BEQ: begin
                  // The branch resolves here: the ALU compares the operands
                  // and the PC is updated in the same cycle.
                  alu_eq  = 1'b1;
                  pc_load = 1'b1;
                  pc_sel  = eq_out ? PC_BRANCH : PC_INC;
                  state_d = run ? FETCH : IDLE;
               end
               OP_JALR: begin
                  alu_pass1 = 1'b1;
                  state_d   = WB;
               end
            endcase
         end

         MEM: begin
            // Keep the effective-address computation alive on the ALU so
            // alu_out stays valid as the memory address until ack.
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_SW);
            alu_add  = 1'b1;
            src2_sel = SRC2_IMM7;
            if (mem_ack) begin
               if (opcode == OP_SW) begin
                  pc_load = 1'b1;
                  state_d = run ? FETCH : IDLE;
               end else begin
                  state_d = WB;
               end
            end
         end

         WB: begin
            rf_we   = 1'b1;
            pc_load = 1'b1;
            if (opcode == OP_LW) begin
               wb_sel = WB_MEM;
            end else if (opcode == OP_JALR) begin
               // JALR writes the link (PC+1) and jumps to regB, which the
               // ALU passes through as alu_out.
               wb_sel    = WB_PC1;
               pc_sel    = PC_ALU;
               alu_pass1 = 1'b1;
            end
            state_d = run ? FETCH : IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// tb_risc_multicycle_ctrl
// -----------------------
// Self-checking bench for risc_multicycle_ctrl. A per-instruction model
// expands each directed instruction (opcode, fetch/memory wait counts, branch
// outcome, run level) into the cycle-by-cycle control outputs it must
// produce, together with the inputs to drive in each cycle. One process
// drives those inputs and compares the outputs of two instances
// (CNT_W = 16 and CNT_W = 2) every cycle; literal checks pin the model.

module tb_risc_multicycle_ctrl;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   // One cycle of the expected trace: inputs to apply, then outputs expected.
   typedef struct packed {
      logic        rst;
      logic        run;
      logic        ack;
      logic        eqo;
      logic [2:0]  op;
      logic [2:0]  st;
      logic        req;
      logic        we;
      logic        asel;
      logic        irl;
      logic        pcl;
      logic [1:0]  pcs;
      logic        add;
      logic        nnd;
      logic        p1;
      logic        eqs;
      logic        s1z;
      logic [1:0]  s2;
      logic        rfwe;
      logic [1:0]  wbs;
      logic [15:0] ret;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [2:0]  opcode;
   logic        eq_out;
   logic        mem_ack;

   logic        mem_req, mem_we, addr_sel, ir_load, pc_load;
   logic [1:0]  pc_sel;
   logic        alu_add, alu_nand, alu_pass1, alu_eq, src1_zero;
   logic [1:0]  src2_sel;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic [15:0] retired;

   logic        mem_req2, mem_we2, addr_sel2, ir_load2, pc_load2;
   logic [1:0]  pc_sel2;
   logic        alu_add2, alu_nand2, alu_pass12, alu_eq2, src1_zero2;
   logic [1:0]  src2_sel2;
   logic        rf_we2;
   logic [1:0]  wb_sel2;
   logic [2:0]  state2;
   logic [1:0]  retired2;

   cyc_t q[$];
   int   m_ret = 0;
   int   errors = 0;
   int   checks = 0;
   int   cyc_no = 0;

   always #5 clk = ~clk;

   risc_multicycle_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .eq_out(eq_out),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_load(ir_load), .pc_load(pc_load),
      .pc_sel(pc_sel), .alu_add(alu_add), .alu_nand(alu_nand),
      .alu_pass1(alu_pass1), .alu_eq(alu_eq), .src1_zero(src1_zero),
      .src2_sel(src2_sel), .rf_we(rf_we), .wb_sel(wb_sel), .state(state),
      .retired(retired)
   );

   risc_multicycle_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .eq_out(eq_out),
      .mem_ack(mem_ack), .mem_req(mem_req2), .mem_we(mem_we2),
      .addr_sel(addr_sel2), .ir_load(ir_load2), .pc_load(pc_load2),
      .pc_sel(pc_sel2), .alu_add(alu_add2), .alu_nand(alu_nand2),
      .alu_pass1(alu_pass12), .alu_eq(alu_eq2), .src1_zero(src1_zero2),
      .src2_sel(src2_sel2), .rf_we(rf_we2), .wb_sel(wb_sel2), .state(state2),
      .retired(retired2)
   );

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic cyc_t blank(input logic [2:0] op, input logic runv,
                                  input logic [2:0] st, input logic eqv);
      cyc_t c = '0;
      c.op  = op;
      c.run = runv;
      c.st  = st;
      c.ack = 1'b1;
      c.eqo = eqv;
      return c;
   endfunction

   // Record the count visible during this cycle; a pc_load retires afterwards.
   task automatic push_rec(input cyc_t c);
      cyc_t r = c;
      r.ret = m_ret[15:0];
      q.push_back(r);
      if (c.pcl) m_ret = (m_ret + 1) % 65536;
   endtask

   task automatic idle(input int n, input logic runv);
      for (int i = 0; i < n; i++) push_rec(blank(OP_ADD, runv, 3'd0, 1'b0));
   endtask

   // Expand one instruction into its expected cycles.
   task automatic build_instr(input logic [2:0] op, input int fetch_wait,
                              input int mem_wait, input logic eqv,
                              input logic runv, output int ncyc);
      cyc_t c;
      int   start = q.size();
      for (int i = 0; i < fetch_wait; i++) begin
         c = blank(op, 1'b1, 3'd1, eqv);
         c.ack = 1'b0;
         c.req = 1'b1;
         push_rec(c);
      end
      c = blank(op, 1'b1, 3'd1, eqv);
      c.req = 1'b1;
      c.irl = 1'b1;
      push_rec(c);
      push_rec(blank(op, runv, 3'd2, eqv));
      c = blank(op, runv, 3'd3, eqv);
      case (op)
         OP_ADD:  c.add = 1'b1;
         OP_ADDI: begin c.add = 1'b1; c.s2 = 2'd1; end
         OP_NAND: c.nnd = 1'b1;
         OP_LUI:  begin c.add = 1'b1; c.s1z = 1'b1; c.s2 = 2'd2; end
         OP_SW, OP_LW: begin c.add = 1'b1; c.s2 = 2'd1; end
         OP_BEQ:  begin c.eqs = 1'b1; c.pcl = 1'b1; c.pcs = eqv ? 2'd1 : 2'd0; end
         default: c.p1 = 1'b1;
      endcase
      push_rec(c);
      if (op == OP_SW || op == OP_LW) begin
         for (int i = 0; i <= mem_wait; i++) begin
            c = blank(op, runv, 3'd4, eqv);
            c.ack  = (i == mem_wait);
            c.req  = 1'b1;
            c.asel = 1'b1;
            c.we   = (op == OP_SW);
            c.add  = 1'b1;
            c.s2   = 2'd1;
            c.pcl  = (i == mem_wait) && (op == OP_SW);
            push_rec(c);
         end
      end
      if (op != OP_SW && op != OP_BEQ) begin
         c = blank(op, runv, 3'd5, eqv);
         c.rfwe = 1'b1;
         c.pcl  = 1'b1;
         if (op == OP_LW) c.wbs = 2'd1;
         if (op == OP_JALR) begin
            c.wbs = 2'd2;
            c.pcs = 2'd2;
            c.p1  = 1'b1;
         end
         push_rec(c);
      end
      ncyc = q.size() - start;
   endtask

   // LW whose memory phase is cut short by reset while the request waits.
   task automatic build_lw_abort(input int mem_wait);
      cyc_t c;
      c = blank(OP_LW, 1'b1, 3'd1, 1'b0);
      c.req = 1'b1;
      c.irl = 1'b1;
      push_rec(c);
      push_rec(blank(OP_LW, 1'b1, 3'd2, 1'b0));
      c = blank(OP_LW, 1'b1, 3'd3, 1'b0);
      c.add = 1'b1;
      c.s2  = 2'd1;
      push_rec(c);
      for (int i = 0; i <= mem_wait; i++) begin
         c = blank(OP_LW, 1'b1, 3'd4, 1'b0);
         c.ack  = 1'b0;
         c.req  = 1'b1;
         c.asel = 1'b1;
         c.add  = 1'b1;
         c.s2   = 2'd1;
         c.rst  = (i == mem_wait);
         push_rec(c);
      end
      m_ret = 0;
   endtask

   // Drive each queued cycle just after the rising edge and compare both
   // instances at the falling edge.
   task automatic apply_stimulus();
      cyc_t        c;
      logic [19:0] exp_v;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         rst     = c.rst;
         run     = c.run;
         opcode  = c.op;
         mem_ack = c.ack;
         eq_out  = c.eqo;
         @(negedge clk);
         exp_v = {c.st, c.req, c.we, c.asel, c.irl, c.pcl, c.pcs, c.add,
                  c.nnd, c.p1, c.eqs, c.s1z, c.s2, c.rfwe, c.wbs};
         check_output($sformatf("ctrl cyc%0d", cyc_no),
            32'({state, mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel,
                 alu_add, alu_nand, alu_pass1, alu_eq, src1_zero, src2_sel,
                 rf_we, wb_sel}), 32'(exp_v));
         check_output($sformatf("ctrl2 cyc%0d", cyc_no),
            32'({state2, mem_req2, mem_we2, addr_sel2, ir_load2, pc_load2,
                 pc_sel2, alu_add2, alu_nand2, alu_pass12, alu_eq2, src1_zero2,
                 src2_sel2, rf_we2, wb_sel2}), 32'(exp_v));
         check_output($sformatf("retired cyc%0d", cyc_no), 32'(retired),
                      32'(c.ret));
         check_output($sformatf("retired2 cyc%0d", cyc_no), 32'(retired2),
                      32'(c.ret[1:0]));
         cyc_no++;
      end
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      run     = 1'b1;
      opcode  = OP_ADD;
      eq_out  = 1'b0;
      mem_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset state", 32'(state), 32'd0);
      check_output("reset mem_req", 32'(mem_req), 32'd0);
      check_output("reset retired", 32'(retired), 32'd0);
      check_output("reset pc_load", 32'(pc_load), 32'd0);

      // ADD then NAND with ack tied high, then stop.
      idle(2, 1'b0);
      idle(1, 1'b1);
      build_instr(OP_ADD, 0, 0, 1'b0, 1'b1, n);
      check_output("len ADD", 32'(n), 32'd4);
      build_instr(OP_NAND, 0, 0, 1'b0, 1'b0, n);
      check_output("len NAND", 32'(n), 32'd4);
      idle(1, 1'b0);
      apply_stimulus();
      check_output("retired after ADD,NAND", 32'(retired), 32'd2);
      check_output("idle after ADD,NAND", 32'(state), 32'd0);

      // Waits, branches, link jump, immediates.
      idle(1, 1'b1);
      build_instr(OP_LW, 0, 3, 1'b0, 1'b1, n);
      check_output("len LW wait3", 32'(n), 32'd8);
      build_instr(OP_BEQ, 0, 0, 1'b1, 1'b1, n);
      check_output("len BEQ taken", 32'(n), 32'd3);
      build_instr(OP_BEQ, 0, 0, 1'b0, 1'b1, n);
      build_instr(OP_JALR, 0, 0, 1'b0, 1'b1, n);
      build_instr(OP_ADDI, 2, 0, 1'b1, 1'b1, n);
      check_output("len ADDI fetch wait2", 32'(n), 32'd6);
      build_instr(OP_LUI, 0, 0, 1'b0, 1'b0, n);
      idle(2, 1'b0);
      apply_stimulus();
      check_output("retired after 8", 32'(retired), 32'd8);
      check_output("retired2 after 8", 32'(retired2), 32'd0);

      // Reset while LW waits in MEM.
      idle(1, 1'b1);
      build_lw_abort(2);
      idle(1, 1'b0);
      apply_stimulus();
      check_output("abort state", 32'(state), 32'd0);
      check_output("abort mem_req", 32'(mem_req), 32'd0);
      check_output("abort retired", 32'(retired), 32'd0);

      // Five SW back to back; run drops during the fifth.
      idle(1, 1'b1);
      build_instr(OP_SW, 0, 0, 1'b0, 1'b1, n);
      check_output("len SW", 32'(n), 32'd4);
      build_instr(OP_SW, 0, 1, 1'b0, 1'b1, n);
      build_instr(OP_SW, 0, 0, 1'b0, 1'b1, n);
      build_instr(OP_SW, 0, 0, 1'b0, 1'b1, n);
      build_instr(OP_SW, 0, 0, 1'b0, 1'b0, n);
      idle(2, 1'b0);
      apply_stimulus();
      check_output("retired2 after 5 SW", 32'(retired2), 32'd1);
      check_output("retired after 5 SW", 32'(retired), 32'd5);
      check_output("idle after 5 SW", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
